// File: rtl/rs232_tx_buffer.sv
// RS232 transmit buffer: 8-entry byte FIFO feeding an 8N1 UART serialiser with a registered tx line.
// Define RS232_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module rs232_tx_buffer #(
    parameter int CLK_DIV    = 434,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            iData_RS232,
    input  logic                  WriteEnable_RS232,
    output logic                  oWrBuffer_full_RS232,
    output logic                  tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RS232_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic                   tx_q, tx_d;
    logic                   pop, wr_en, baud_zero;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic [7:0]             mem [DEPTH];
`ifdef RS232_TX_PARITY_EN
    logic                   parity_q;
`endif

    assign wr_en                = WriteEnable_RS232 && (count_q != (DEPTH_LOG2+1)'(DEPTH));
    assign baud_zero            = (baud_q == '0);
    assign oWrBuffer_full_RS232 = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign count                = count_q;
    assign tx                   = tx_q;
    assign busy                 = (state_q != IDLE);

    // Storage has no reset; only the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= iData_RS232;
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
`ifdef RS232_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            count_q <= count_d;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
`ifdef RS232_TX_PARITY_EN
            if (pop)   parity_q <= ^mem[rd_ptr];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    shift_d = mem[rd_ptr];
                    pop     = 1'b1;
                    baud_d  = BAUD_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (baud_zero) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (baud_zero) begin
                    shift_d = shift_q >> 1;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef RS232_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef RS232_TX_PARITY_EN
            PARITY: begin
                if (baud_zero) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_zero) state_d = IDLE;
                else           baud_d  = baud_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is derived from the upcoming state so the registered line changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef RS232_TX_PARITY_EN
            PARITY:  tx_d = pop ? (^mem[rd_ptr]) : parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_rs232_tx_buffer.sv
// Randomised scoreboard bench for rs232_tx_buffer (CLK_DIV=4); a frame-level model predicts
// occupancy, busy and the line, and a serial decoder checks the bytes against a scoreboard queue.
module tb_rs232_tx_buffer;

    localparam int CLK_DIV = 4;
`ifdef RS232_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       we = 1'b0;
    logic       full, tx, busy;
    logic [3:0] count;

    int total = 0;
    int bad = 0;
    bit final_check = 1'b0;
    bit final_done = 1'b0;

    logic [7:0] m_fifo [$];
    logic [7:0] sb [$];
    logic [7:0] m_cur = 8'h00;
    int         m_left = 0;

    rs232_tx_buffer #(.CLK_DIV(CLK_DIV), .DEPTH_LOG2(3)) dut (
        .clk(clk),
        .rst(rst),
        .iData_RS232(data),
        .WriteEnable_RS232(we),
        .oWrBuffer_full_RS232(full),
        .tx(tx),
        .busy(busy),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic w);
        @(posedge clk);
        #2;
        data = d;
        we   = w;
    endtask

    function automatic logic expectedTx();
        int j, b;
        if (m_left == 0) return 1'b1;
        j = FRAME - m_left;
        b = j / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
`ifdef RS232_TX_PARITY_EN
        if (b == 9) return ^m_cur;
`endif
        return 1'b1;
    endfunction

    // Frame-level reference: one line frame of FRAME cycles per byte, popped whenever the line is free.
    initial begin
        bit acc, pop;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_fifo.delete();
                sb.delete();
                m_left = 0;
            end else begin
                acc = we && (m_fifo.size() < 8);
                pop = (m_left == 0) && (m_fifo.size() != 0);
                if (pop) begin
                    m_cur  = m_fifo.pop_front();
                    m_left = FRAME;
                end else if (m_left > 0) begin
                    m_left--;
                end
                if (acc) begin
                    m_fifo.push_back(data);
                    sb.push_back(data);
                end
            end
        end
    end

    // Monitor: cycle checks against the model plus a mid-bit serial decoder feeding the scoreboard.
    initial begin
        bit         active = 1'b0;
        int         k = 0;
        logic [7:0] shreg = 8'h00;
        forever begin
            @(negedge clk);
            checkOutput("count", 32'(count), 32'(m_fifo.size()));
            checkOutput("full", 32'(full), 32'(m_fifo.size() == 8));
            checkOutput("busy", 32'(busy), 32'(m_left != 0));
            checkOutput("tx", 32'(tx), 32'(expectedTx()));
            if (rst) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    if (tx == 1'b0) begin
                        active = 1'b1;
                        k = 0;
                    end
                end else begin
                    k++;
                end
                if (active) begin
                    if (k == CLK_DIV/2) checkOutput("start_bit", 32'(tx), 32'd0);
                    for (int i = 1; i <= 8; i++)
                        if (k == i*CLK_DIV + CLK_DIV/2) shreg[i-1] = tx;
`ifdef RS232_TX_PARITY_EN
                    if (k == 9*CLK_DIV + CLK_DIV/2) checkOutput("parity_bit", 32'(tx), 32'(^shreg));
`endif
                    if (k == (NBITS-1)*CLK_DIV + CLK_DIV/2) begin
                        checkOutput("stop_bit", 32'(tx), 32'd1);
                        if (sb.size() == 0) checkOutput("unexpected_frame", 32'(shreg), 32'hFFFF_FFFF);
                        else                checkOutput("byte", 32'(shreg), 32'(sb.pop_front()));
                        active = 1'b0;
                    end
                end
            end
            if (final_check && !final_done) begin
                checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
                checkOutput("decoder_idle", 32'(active), 32'd0);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (100) applyStimulus(8'h00, 1'b0);

        applyStimulus(8'hA5, 1'b1);
        repeat (60) applyStimulus(8'h00, 1'b0);

        for (int i = 0; i <= 8; i++) applyStimulus(8'(i), 1'b1);
        applyStimulus(8'hFF, 1'b1);
        repeat (9*(FRAME+1) + 20) applyStimulus(8'h00, 1'b0);

        applyStimulus(8'h5A, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        repeat (2*(FRAME+1) + 20) applyStimulus(8'h00, 1'b0);

        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        repeat (15) applyStimulus(8'h00, 1'b0);
        rst = 1'b1;
        repeat (2) applyStimulus(8'h00, 1'b0);
        rst = 1'b0;
        repeat (100) applyStimulus(8'h00, 1'b0);

        applyStimulus(8'h07, 1'b1);
        applyStimulus(8'h03, 1'b1);
        repeat (2*(FRAME+1) + 20) applyStimulus(8'h00, 1'b0);

        for (int i = 0; i < 400; i++)
            applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
        repeat (9*(FRAME+1) + 40) applyStimulus(8'h00, 1'b0);

        final_check = 1'b1;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
